// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the attached
// device (for example 0xED LED set, 0xFF reset, or 0xF3 typematic). It drives
// the shared PS/2 clock and data lines open-drain through two output-enables;
// the top level turns each enable into 0/z.
//
// Sequence per byte: bus inhibit (clock held low), request-to-send (data low,
// then clock released), 10 device-clocked bits (data LSB first, odd parity,
// stop), then the device ACK is checked.
//
// Parameters:
//   INHIBIT_CYCLES  clock-low hold before request-to-send (default 100 us @ 50 MHz)
//   TIMEOUT_CYCLES  max gap between device clock falling edges (default 15 ms)
//
// Ports:
//   m_clock     system clock, the only clock
//   p_reset     synchronous active-high reset
//   tx_data     command byte, sampled only on the accept cycle
//   tx_start    request pulse, accepted only while tx_busy is low
//   tx_busy     high from the cycle after accept until tx_done / tx_error
//   tx_done     1-cycle pulse: ACK received and bus back to idle
//   tx_error    1-cycle pulse: NACK or timeout
//   ps2_clk_in  raw PS2_CLK pin (asynchronous)
//   ps2_dat_in  raw PS2_DAT pin (asynchronous)
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
//
// Build option:
//   PS2_HOST_TX_RETRY_EN  when defined, a failed attempt re-enters the inhibit
//                         phase with the latched byte. Up to 3 attempts are made,
//                         and tx_error is reported only after the third failure.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves both the inhibit hold and the inter-edge timeout.
  localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StRts      = 3'd2;
  localparam logic [2:0] StSend     = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;

  // Pin synchronisers, plus a history flop on the clock for edge detection.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  // {stop, parity, data[7:0]}, indexed by bit_q rather than shifted, so a retry
  // can replay the same frame.
  logic [9:0]      frame_q, frame_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            fail;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]      attempt_q, attempt_d;
`endif

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    fail     = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    attempt_d = attempt_q;
`endif

    unique case (state_q)
      StIdle: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_start) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          bit_d    = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
`ifdef PS2_HOST_TX_RETRY_EN
          attempt_d = '0;
`endif
        end
      end

      // Device clock edges seen here and in StRts are our own pull-down (or a
      // device still finishing a frame), so they are deliberately ignored.
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = StRts;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StRts: begin
        // Start bit stays on data; the device takes over the clock.
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        bit_d    = '0;
        state_d  = StSend;
      end

      StSend: begin
        if (fall) begin
          // An edge always beats a coincident timeout.
          cnt_d    = '0;
          dat_oe_d = ~frame_q[bit_q];
          if (bit_q == 4'd9) begin
            state_d = StAck;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else if (cnt_q == TimeoutLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StAck: begin
        if (fall) begin
          cnt_d = '0;
          if (dat_sync_q) begin
            fail = 1'b1;
          end else begin
            state_d = StWaitIdle;
          end
        end else if (cnt_q == TimeoutLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StWaitIdle: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
    endcase

    // Failure is resolved in the cycle it is detected: release the bus and
    // either report or start the next attempt.
    if (fail) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      cnt_d    = '0;
      bit_d    = '0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (attempt_q == 2'd2) begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end else begin
        attempt_d = attempt_q + 2'd1;
        clk_oe_d  = 1'b1;
        state_d   = StInhibit;
      end
`else
      error_d = 1'b1;
      busy_d  = 1'b0;
      state_d = StIdle;
`endif
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      attempt_q  <= '0;
`endif
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PS2_HOST_TX_RETRY_EN
      attempt_q  <= attempt_d;
`endif
    end
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
